// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
//   owner_t   : which requester owns the read response due next cycle
//   mem_req_t : one memory request (we/addr/wdata), fields sized for up to 32-bit ports
//   ALIGN_MASK: byte-address bits that must be zero for a word access
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Grant logic for the two data-memory requesters.
// Default build: CPU priority; DBG gets a forced grant after losing DBG_WAIT_MAX
// consecutive cycles. With DMEM_ARB_RR_EN defined, conflicts alternate between ports
// instead and no wait counter exists.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cpu_req_i, dbg_req_i  requests
//   cpu_gnt_o, dbg_gnt_o  one-hot (or zero) grant for the current cycle
module dmem_arb_grant #(
    parameter int unsigned DBG_WAIT_MAX = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cpu_req_i,
    input  logic dbg_req_i,
    output logic cpu_gnt_o,
    output logic dbg_gnt_o
);

`ifdef DMEM_ARB_RR_EN

    // 1: DBG wins the next conflict; flips on every conflict.
    logic prio_dbg_q, prio_dbg_d;
    logic conflict;

    always_comb begin
        conflict   = cpu_req_i & dbg_req_i;
        prio_dbg_d = prio_dbg_q;
        cpu_gnt_o  = 1'b0;
        dbg_gnt_o  = 1'b0;
        if (!rst_i) begin
            if (conflict) begin
                dbg_gnt_o  = prio_dbg_q;
                cpu_gnt_o  = ~prio_dbg_q;
                prio_dbg_d = ~prio_dbg_q;
            end else begin
                cpu_gnt_o = cpu_req_i;
                dbg_gnt_o = dbg_req_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_dbg_q <= 1'b0;
        end else begin
            prio_dbg_q <= prio_dbg_d;
        end
    end

`else

    localparam int unsigned CntW = $clog2(DBG_WAIT_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DBG_WAIT_MAX);

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            dbg_force;

    always_comb begin
        dbg_force  = dbg_req_i & (wait_cnt_q == CntMax);
        cpu_gnt_o  = 1'b0;
        dbg_gnt_o  = 1'b0;
        if (!rst_i) begin
            dbg_gnt_o = dbg_req_i & (~cpu_req_i | dbg_force);
            cpu_gnt_o = cpu_req_i & ~dbg_gnt_o;
        end
        // Counts consecutive lost cycles; any grant or dropped request restarts aging.
        if (!dbg_req_i || dbg_gnt_o) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CntMax) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage (CPU) and the
// debug/preload port (DBG). One access per cycle, 1-cycle read latency routed back to
// the owner, CPU stalled whenever its request is not granted.
// Config macro: DMEM_ARB_RR_EN selects round-robin arbitration instead of CPU priority
// with DBG aging.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i     MEM stage request
//   cpu_stall_o/rdata_o/rvalid_o      stall and load response
//   dbg_req_i/we_i/addr_i/wdata_i     debug request (held until dbg_gnt_o)
//   dbg_gnt_o/rdata_o/rvalid_o        debug accept and read response
//   misalign_err_o                    granted access had addr[1:0] != 0
//   mem_en_o/we_o/addr_o/wdata_o      memory drive
//   mem_rdata_i                       memory read data, one cycle after a read strobe
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DBG_WAIT_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_stall_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_rvalid_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_rvalid_o,
    output logic              misalign_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    logic     cpu_gnt, dbg_gnt, gnt_any, aligned;
    mem_req_t cpu_s, dbg_s, gnt_s;
    owner_t   rsp_owner_q, rsp_owner_d;
    logic     rsp_zero_q, rsp_zero_d;

    dmem_arb_grant #(
        .DBG_WAIT_MAX (DBG_WAIT_MAX)
    ) u_grant (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cpu_req_i (cpu_req_i),
        .dbg_req_i (dbg_req_i),
        .cpu_gnt_o (cpu_gnt),
        .dbg_gnt_o (dbg_gnt)
    );

    // Request mux and memory drive.
    always_comb begin
        cpu_s.we       = cpu_we_i;
        cpu_s.addr     = 32'(cpu_addr_i);
        cpu_s.wdata    = 32'(cpu_wdata_i);
        dbg_s.we       = dbg_we_i;
        dbg_s.addr     = 32'(dbg_addr_i);
        dbg_s.wdata    = 32'(dbg_wdata_i);
        gnt_any        = cpu_gnt | dbg_gnt;
        gnt_s          = dbg_gnt ? dbg_s : cpu_s;
        aligned        = is_aligned(gnt_s.addr[1:0]);
        mem_en_o       = gnt_any & aligned;
        mem_we_o       = gnt_any & gnt_s.we;
        mem_addr_o     = gnt_any ? ADDR_W'(gnt_s.addr) : '0;
        mem_wdata_o    = gnt_any ? DATA_W'(gnt_s.wdata) : '0;
        misalign_err_o = gnt_any & ~aligned;
        cpu_stall_o    = ~rst_i & cpu_req_i & ~cpu_gnt;
        dbg_gnt_o      = dbg_gnt;
    end

    // Response FSM next state: owner of this cycle's granted read, if any.
    always_comb begin
        rsp_owner_d = OWN_NONE;
        rsp_zero_d  = ~aligned;
        if (dbg_gnt && !dbg_we_i) begin
            rsp_owner_d = OWN_DBG;
        end else if (cpu_gnt && !cpu_we_i) begin
            rsp_owner_d = OWN_CPU;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_owner_q <= OWN_NONE;
            rsp_zero_q  <= 1'b0;
        end else begin
            rsp_owner_q <= rsp_owner_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    // Reset also masks a response already in flight so nothing escapes the reset cycle.
    always_comb begin
        cpu_rvalid_o = ~rst_i & (rsp_owner_q == OWN_CPU);
        dbg_rvalid_o = ~rst_i & (rsp_owner_q == OWN_DBG);
        cpu_rdata_o  = (cpu_rvalid_o && !rsp_zero_q) ? mem_rdata_i : '0;
        dbg_rdata_o  = (dbg_rvalid_o && !rsp_zero_q) ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a small behavioural data memory.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        misalign_err, mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (32),
        .DBG_WAIT_MAX (8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cpu_req_i      (cpu_req),
        .cpu_we_i       (cpu_we),
        .cpu_addr_i     (cpu_addr),
        .cpu_wdata_i    (cpu_wdata),
        .cpu_stall_o    (cpu_stall),
        .cpu_rdata_o    (cpu_rdata),
        .cpu_rvalid_o   (cpu_rvalid),
        .dbg_req_i      (dbg_req),
        .dbg_we_i       (dbg_we),
        .dbg_addr_i     (dbg_addr),
        .dbg_wdata_i    (dbg_wdata),
        .dbg_gnt_o      (dbg_gnt),
        .dbg_rdata_o    (dbg_rdata),
        .dbg_rvalid_o   (dbg_rvalid),
        .misalign_err_o (misalign_err),
        .mem_en_o       (mem_en),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    // Single-port memory model: read data appears the cycle after a read strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic cpu_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic dbg_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem_rdata = '0;
        rst = 1'b1;
        idle();
        next_cycle();
        @(negedge clk);
        check("rst_stall",  {31'b0, cpu_stall},  32'd0);
        check("rst_gnt",    {31'b0, dbg_gnt},    32'd0);
        check("rst_mem_en", {31'b0, mem_en},     32'd0);
        check("rst_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // CPU write then read.
        cpu_drive(1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_wr_en",    {31'b0, mem_en},    32'd1);
        check("t1_wr_we",    {31'b0, mem_we},    32'd1);
        check("t1_wr_addr",  mem_addr,           32'h10);
        check("t1_wr_data",  mem_wdata,          32'hDEADBEEF);
        check("t1_wr_stall", {31'b0, cpu_stall}, 32'd0);
        next_cycle();
        check("t1_wr_norv",  {31'b0, cpu_rvalid}, 32'd0);
        cpu_drive(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("t1_rd_en",    {31'b0, mem_en},    32'd1);
        check("t1_rd_we",    {31'b0, mem_we},    32'd0);
        check("t1_rd_stall", {31'b0, cpu_stall}, 32'd0);
        check("t1_rd_norv",  {31'b0, cpu_rvalid}, 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        check("t1_rvalid",   {31'b0, cpu_rvalid}, 32'd1);
        check("t1_rdata",    cpu_rdata,           32'hDEADBEEF);
        check("t1_dbg_rv",   {31'b0, dbg_rvalid}, 32'd0);
        next_cycle();

        // Misaligned CPU read; memory read register still holds 0xDEADBEEF.
        cpu_drive(1'b0, 32'h13, 32'h0);
        @(negedge clk);
        check("t3_mem_en",   {31'b0, mem_en},       32'd0);
        check("t3_err",      {31'b0, misalign_err}, 32'd1);
        check("t3_stall",    {31'b0, cpu_stall},    32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        check("t3_rvalid",   {31'b0, cpu_rvalid},   32'd1);
        check("t3_rdata",    cpu_rdata,             32'h0);
        check("t3_err_off",  {31'b0, misalign_err}, 32'd0);
        next_cycle();

        // Both ports requesting continuously.
        cpu_drive(1'b0, 32'h40, 32'h0);
        dbg_drive(1'b0, 32'h44, 32'h0);
        for (int k = 0; k < 18; k++) begin
            logic exp_dbg;
`ifdef DMEM_ARB_RR_EN
            exp_dbg = (k % 2) == 1;
`else
            exp_dbg = (k % 9) == 8;
`endif
            @(negedge clk);
            check($sformatf("t2_gnt_%0d", k),   {31'b0, dbg_gnt},   {31'b0, exp_dbg});
            check($sformatf("t2_stall_%0d", k), {31'b0, cpu_stall}, {31'b0, exp_dbg});
            next_cycle();
        end
        idle();
        next_cycle();

        // Preload via DBG and CPU, then back-to-back reads from both ports.
        dbg_drive(1'b1, 32'h20, 32'h11112222);
        @(negedge clk);
        check("t5_dbg_wgnt", {31'b0, dbg_gnt}, 32'd1);
        next_cycle();
        idle();
        cpu_drive(1'b1, 32'h24, 32'h33334444);
        next_cycle();
        idle();
        dbg_drive(1'b0, 32'h20, 32'h0);
        @(negedge clk);
        check("t5_dbg_rgnt", {31'b0, dbg_gnt}, 32'd1);
        next_cycle();
        idle();
        cpu_drive(1'b0, 32'h24, 32'h0);
        @(negedge clk);
        check("t5_dbg_rv",   {31'b0, dbg_rvalid}, 32'd1);
        check("t5_dbg_rd",   dbg_rdata,           32'h11112222);
        check("t5_cpu_rv0",  {31'b0, cpu_rvalid}, 32'd0);
        check("t5_cpu_rd0",  cpu_rdata,           32'h0);
        next_cycle();
        idle();
        @(negedge clk);
        check("t5_cpu_rv",   {31'b0, cpu_rvalid}, 32'd1);
        check("t5_cpu_rd",   cpu_rdata,           32'h33334444);
        check("t5_dbg_rv0",  {31'b0, dbg_rvalid}, 32'd0);
        check("t5_dbg_rd0",  dbg_rdata,           32'h0);
        next_cycle();

        // Reset in the cycle after a DBG read grant drops the response.
        dbg_drive(1'b0, 32'h20, 32'h0);
        @(negedge clk);
        check("t4_gnt",      {31'b0, dbg_gnt}, 32'd1);
        next_cycle();
        idle();
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_rv",   {31'b0, dbg_rvalid}, 32'd0);
        check("t4_rst_rd",   dbg_rdata,           32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t4_post_rv",  {30'b0, cpu_rvalid, dbg_rvalid}, 32'd0);
        check("t4_post_ctl", {27'b0, cpu_stall, dbg_gnt, misalign_err, mem_en, mem_we}, 32'd0);
        check("t4_post_rd",  cpu_rdata | dbg_rdata, 32'h0);
        check("t4_post_mem", mem_addr | mem_wdata,  32'h0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
